// File: rtl/cpu_mode_pkg.sv
// cpu_mode_pkg: shared encodings for the front-panel mode sequencer.
//   mode_e : front-panel modes; the same encoding appears on CPUstate and mode_req.
//   acc_e  : memory access phase. ACC_WR is the write-strobe cycle.
//            ACC_RD is the read-strobe cycle. ACC_CAP is the cycle in which
//            read data is valid and gets captured.
package cpu_mode_pkg;

    typedef enum logic [1:0] {
        MODE_IDLE  = 2'b00,
        MODE_IN    = 2'b01,
        MODE_CHECK = 2'b10,
        MODE_RUN   = 2'b11
    } mode_e;

    typedef enum logic [1:0] {
        ACC_NONE = 2'b00,
        ACC_WR   = 2'b01,
        ACC_RD   = 2'b10,
        ACC_CAP  = 2'b11
    } acc_e;

endpackage

// File: rtl/cpu_mode_ctrl_key_edge.sv
// key_edge: registered rising-edge detector for one front-panel key.
//   clk   in  : system clock
//   rst   in  : async active-high reset
//   key   in  : key level
//   pulse out : one-cycle pulse in the cycle after the key is first seen high
// The history register resets to 1. As a result, a key held through reset
// does not fire when reset is released.
module key_edge (
    input  logic clk,
    input  logic rst,
    input  logic key,
    output logic pulse
);

    logic key_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            key_q <= 1'b1;
            pulse <= 1'b0;
        end else begin
            key_q <= key;
            pulse <= key & ~key_q;
        end
    end

endmodule

// File: rtl/cpu_mode_ctrl.sv
// cpu_mode_ctrl: front-panel mode sequencer for the 8-bit teaching CPU.
//   clk, rst            : clock, async active-high reset
//   mode_req[1:0]       : requested mode (00 IDLE, 01 IN, 10 CHECK, 11 RUN)
//   mode_load, step     : key levels; edge-detected internally
//   sw_data             : byte written in IN mode
//   mem_rdata           : memory read data, valid the cycle after mem_re
//   CPUstate, cpu_run   : current mode; run-enable for the controller (RUN only)
//   own_mem             : this block owns the memory port (IN, CHECK)
//   mem_addr/wdata/we/re: memory port
//   disp_data           : last byte written or read back
//   prog_len            : bytes written since the last entry to IN (saturating)
//   checksum            : mod-256 sum of written bytes
// Build option: the CHECKSUM_EN macro builds the checksum accumulator.
//   If CHECKSUM_EN is not defined, checksum is tied to 0.
module cpu_mode_ctrl
    import cpu_mode_pkg::*;
#(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        mode_req,
    input  logic              mode_load,
    input  logic              step,
    input  logic [DATA_W-1:0] sw_data,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [1:0]        CPUstate,
    output logic              cpu_run,
    output logic              own_mem,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    output logic              mem_re,
    output logic [DATA_W-1:0] disp_data,
    output logic [ADDR_W-1:0] prog_len,
    output logic [DATA_W-1:0] checksum
);

    localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

    logic  load_p, step_p;
    mode_e state, pend_mode, tgt;
    acc_e  acc;
    logic  pend;
    logic  acc_done, load_now, start_step;

    key_edge u_load_edge (.clk(clk), .rst(rst), .key(mode_load), .pulse(load_p));
    key_edge u_step_edge (.clk(clk), .rst(rst), .key(step),      .pulse(step_p));

    // A mode load is applied when no access is in flight. It may also be
    // applied on the final cycle of an access (the WR cycle or the CAP cycle).
    // Otherwise the load is parked in pend and pend_mode.
    always_comb begin
        acc_done   = (acc == ACC_WR) || (acc == ACC_CAP);
        load_now   = (load_p || pend) && ((acc == ACC_NONE) || acc_done);
        tgt        = load_p ? mode_e'(mode_req) : pend_mode;
        start_step = step_p && !load_p && (acc == ACC_NONE) &&
                     ((state == MODE_IN) || (state == MODE_CHECK));
    end

    assign CPUstate = state;
    assign mem_we   = (acc == ACC_WR);
    assign mem_re   = (acc == ACC_RD);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= MODE_IDLE;
            pend_mode <= MODE_IDLE;
            pend      <= 1'b0;
            acc       <= ACC_NONE;
            cpu_run   <= 1'b0;
            own_mem   <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            disp_data <= '0;
            prog_len  <= '0;
        end else begin
            if (load_now) begin
                pend <= 1'b0;
            end else if (load_p) begin
                pend      <= 1'b1;
                pend_mode <= mode_e'(mode_req);
            end

            case (acc)
                ACC_NONE: begin
                    if (start_step) begin
                        if (state == MODE_IN) begin
                            acc       <= ACC_WR;
                            mem_wdata <= sw_data;
                            disp_data <= sw_data;
                        end else begin
                            acc <= ACC_RD;
                        end
                    end
                end
                ACC_WR: begin
                    acc      <= ACC_NONE;
                    mem_addr <= mem_addr + ADDR_ONE;
                    if (prog_len != {ADDR_W{1'b1}})
                        prog_len <= prog_len + ADDR_ONE;
                end
                ACC_RD:  acc <= ACC_CAP;
                ACC_CAP: begin
                    acc       <= ACC_NONE;
                    disp_data <= mem_rdata;
                    mem_addr  <= mem_addr + ADDR_ONE;
                end
                default: acc <= ACC_NONE;
            endcase

            // Mode entry comes last so that its pointer clears override the
            // end-of-access increment on the same edge.
            if (load_now) begin
                state   <= tgt;
                cpu_run <= (tgt == MODE_RUN);
                own_mem <= (tgt == MODE_IN) || (tgt == MODE_CHECK);
                if (tgt == MODE_IN) begin
                    mem_addr <= '0;
                    prog_len <= '0;
                end else if (tgt == MODE_CHECK) begin
                    mem_addr <= '0;
                end
            end
        end
    end

`ifdef CHECKSUM_EN
    logic [DATA_W-1:0] csum;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            csum <= '0;
        else if (load_now && (tgt == MODE_IN))
            csum <= '0;
        else if (acc == ACC_WR)
            csum <= csum + mem_wdata;
    end

    assign checksum = csum;
`else
    assign checksum = '0;
`endif

endmodule

// File: tb/tb_cpu_mode_ctrl.sv
// tb_cpu_mode_ctrl: randomized self-checking bench for cpu_mode_ctrl.
// The DUT uses a narrow address so that address wrap and length saturation
// can be reached quickly. The memory is modelled behaviourally. Expected
// values come from a byte array plus counters that follow the front-panel rules.
module tb_cpu_mode_ctrl;

    localparam int AW = 10;
    localparam int DW = 8;
`ifdef CHECKSUM_EN
    localparam bit CSUM_ON = 1'b1;
`else
    localparam bit CSUM_ON = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic [1:0]    mode_req;
    logic          mode_load, step;
    logic [DW-1:0] sw_data, mem_rdata;
    logic [1:0]    CPUstate;
    logic          cpu_run, own_mem, mem_we, mem_re;
    logic [AW-1:0] mem_addr, prog_len;
    logic [DW-1:0] mem_wdata, disp_data, checksum;

    cpu_mode_ctrl #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .rst(rst), .mode_req(mode_req), .mode_load(mode_load),
        .step(step), .sw_data(sw_data), .mem_rdata(mem_rdata),
        .CPUstate(CPUstate), .cpu_run(cpu_run), .own_mem(own_mem),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
        .mem_re(mem_re), .disp_data(disp_data), .prog_len(prog_len),
        .checksum(checksum)
    );

    always #5 clk = ~clk;

    // Memory: synchronous write; read data is registered one cycle after mem_re.
    logic [DW-1:0] tb_mem [0:(1<<AW)-1];
    always @(posedge clk) begin
        if (mem_we) tb_mem[mem_addr] <= mem_wdata;
        if (mem_re) mem_rdata <= tb_mem[mem_addr];
    end

    int checks = 0;
    int errors = 0;

    // Reference state, derived from the front-panel rules.
    logic [DW-1:0] mdl [0:(1<<AW)-1];
    logic [AW-1:0] exp_addr, exp_len;
    logic [DW-1:0] exp_sum, exp_disp;
    localparam logic [AW-1:0] LEN_MAX = '1;

    function automatic logic [DW-1:0] exp_csum();
        return CSUM_ON ? exp_sum : 8'h00;
    endfunction

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Leaves time just after the edge where the new mode is visible.
    task automatic press_load(input logic [1:0] m);
        mode_req  = m;
        mode_load = 1'b1;
        tick(1);
        mode_load = 1'b0;
        tick(1);
        if (m == 2'b01) begin
            exp_addr = '0; exp_len = '0; exp_sum = '0;
        end else if (m == 2'b10) begin
            exp_addr = '0;
        end
    endtask

    // Leaves time inside the first access cycle (WR or RD).
    task automatic press_step();
        step = 1'b1;
        tick(1);
        step = 1'b0;
        tick(1);
    endtask

    // Model update for one completed write.
    task automatic model_write(input logic [DW-1:0] d);
        mdl[exp_addr] = d;
        exp_addr = exp_addr + 1'b1;
        if (exp_len != LEN_MAX) exp_len = exp_len + 1'b1;
        exp_sum  = exp_sum + d;
        exp_disp = d;
    endtask

    task automatic test_reset();
        rst = 1'b1; step = 1'b1; mode_load = 1'b1; mode_req = 2'b01;
        sw_data = 8'hA5;
        #1;
        checks++;
        if ({CPUstate, cpu_run, own_mem, mem_we, mem_re} !== 6'b0) begin
            errors++;
            $display("FAIL reset_ctrl got %b exp 000000", {CPUstate, cpu_run, own_mem, mem_we, mem_re});
        end
        checks++;
        if (mem_addr !== '0 || prog_len !== '0) begin
            errors++;
            $display("FAIL reset_ptr got addr=%0h len=%0h exp 0/0", mem_addr, prog_len);
        end
        checks++;
        if (mem_wdata !== 8'h00 || disp_data !== 8'h00 || checksum !== 8'h00) begin
            errors++;
            $display("FAIL reset_data got wd=%0h disp=%0h cs=%0h exp 0", mem_wdata, disp_data, checksum);
        end
        tick(2);
        rst = 1'b0;
        // Keys still held: neither may fire after reset release.
        for (int i = 0; i < 4; i++) begin
            tick(1);
            checks++;
            if (CPUstate !== 2'b00 || mem_we !== 1'b0 || mem_re !== 1'b0) begin
                errors++;
                $display("FAIL held_keys cyc%0d got st=%b we=%b re=%b exp 00/0/0", i, CPUstate, mem_we, mem_re);
            end
        end
        step = 1'b0; mode_load = 1'b0;
        tick(2);
        exp_addr = '0; exp_len = '0; exp_sum = '0; exp_disp = '0;
    endtask

    task automatic test_enter_in();
        press_load(2'b01);
        checks++;
        if (CPUstate !== 2'b01 || own_mem !== 1'b1 || cpu_run !== 1'b0) begin
            errors++;
            $display("FAIL enter_in got st=%b own=%b run=%b exp 01/1/0", CPUstate, own_mem, cpu_run);
        end
        checks++;
        if (mem_we !== 1'b0 || mem_addr !== '0 || prog_len !== '0) begin
            errors++;
            $display("FAIL enter_in_ptr got we=%b addr=%0h len=%0h exp 0/0/0", mem_we, mem_addr, prog_len);
        end
    endtask

    // Writes one byte and checks the strobe cycle and the cycle after it.
    task automatic test_in_writes(input int n, input bit fixed);
        logic [DW-1:0] vals [3];
        logic [DW-1:0] d;
        vals[0] = 8'h15; vals[1] = 8'h2A; vals[2] = 8'hFF;
        for (int i = 0; i < n; i++) begin
            d = fixed ? vals[i] : DW'($urandom);
            sw_data = d;
            press_step();
            sw_data = DW'($urandom);
            checks++;
            if (mem_we !== 1'b1 || mem_addr !== exp_addr || mem_wdata !== d || disp_data !== d) begin
                errors++;
                $display("FAIL wr%0d_strobe got we=%b a=%0h wd=%0h disp=%0h exp 1/%0h/%0h/%0h",
                         i, mem_we, mem_addr, mem_wdata, disp_data, exp_addr, d, d);
            end
            model_write(d);
            tick(1);
            checks++;
            if (mem_we !== 1'b0 || mem_addr !== exp_addr || prog_len !== exp_len || checksum !== exp_csum()) begin
                errors++;
                $display("FAIL wr%0d_after got we=%b a=%0h len=%0h cs=%0h exp 0/%0h/%0h/%0h",
                         i, mem_we, mem_addr, prog_len, checksum, exp_addr, exp_len, exp_csum());
            end
            if (!fixed) tick($urandom_range(0, 2));
        end
        if (fixed) begin
            checks++;
            if (prog_len !== 10'd3 || checksum !== (CSUM_ON ? 8'h3E : 8'h00) || disp_data !== 8'hFF) begin
                errors++;
                $display("FAIL in_summary got len=%0h cs=%0h disp=%0h exp 3/%0h/ff",
                         prog_len, checksum, disp_data, CSUM_ON ? 8'h3E : 8'h00);
            end
        end
    endtask

    task automatic test_check(input int n);
        press_load(2'b10);
        checks++;
        if (CPUstate !== 2'b10 || own_mem !== 1'b1 || mem_addr !== '0 ||
            prog_len !== exp_len || checksum !== exp_csum()) begin
            errors++;
            $display("FAIL enter_check got st=%b own=%b a=%0h len=%0h cs=%0h exp 10/1/0/%0h/%0h",
                     CPUstate, own_mem, mem_addr, prog_len, checksum, exp_len, exp_csum());
        end
        for (int i = 0; i < n; i++) begin
            press_step();
            checks++;
            if (mem_re !== 1'b1 || mem_we !== 1'b0 || mem_addr !== exp_addr || disp_data !== exp_disp) begin
                errors++;
                $display("FAIL rd%0d_strobe got re=%b we=%b a=%0h disp=%0h exp 1/0/%0h/%0h",
                         i, mem_re, mem_we, mem_addr, disp_data, exp_addr, exp_disp);
            end
            tick(1);
            checks++;
            if (mem_re !== 1'b0 || disp_data !== exp_disp) begin
                errors++;
                $display("FAIL rd%0d_cap got re=%b disp=%0h exp 0/%0h", i, mem_re, disp_data, exp_disp);
            end
            exp_disp = mdl[exp_addr];
            exp_addr = exp_addr + 1'b1;
            tick(1);
            checks++;
            if (disp_data !== exp_disp || mem_addr !== exp_addr || prog_len !== exp_len) begin
                errors++;
                $display("FAIL rd%0d_data got disp=%0h a=%0h len=%0h exp %0h/%0h/%0h",
                         i, disp_data, mem_addr, prog_len, exp_disp, exp_addr, exp_len);
            end
            tick($urandom_range(0, 2));
        end
    endtask

    // A mode load that arrives during a read is held until the capture edge.
    task automatic test_pending_load();
        press_load(2'b10);
        step = 1'b1;
        tick(1);
        step = 1'b0; mode_req = 2'b00; mode_load = 1'b1;
        tick(1);
        mode_load = 1'b0;
        checks++;
        if (mem_re !== 1'b1 || CPUstate !== 2'b10) begin
            errors++;
            $display("FAIL pend_rd got re=%b st=%b exp 1/10", mem_re, CPUstate);
        end
        tick(1);
        checks++;
        if (CPUstate !== 2'b10) begin
            errors++;
            $display("FAIL pend_cap got st=%b exp 10", CPUstate);
        end
        exp_disp = mdl[0];
        exp_addr = 10'd1;
        tick(1);
        checks++;
        if (CPUstate !== 2'b00 || own_mem !== 1'b0 || disp_data !== exp_disp || mem_addr !== exp_addr) begin
            errors++;
            $display("FAIL pend_apply got st=%b own=%b disp=%0h a=%0h exp 00/0/%0h/%0h",
                     CPUstate, own_mem, disp_data, mem_addr, exp_disp, exp_addr);
        end
        press_step();
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (mem_we !== 1'b0 || mem_re !== 1'b0) begin
                errors++;
                $display("FAIL idle_step%0d got we=%b re=%b exp 0/0", i, mem_we, mem_re);
            end
            tick(1);
        end
    endtask

    task automatic test_same_edge();
        press_load(2'b01);
        sw_data = 8'h77;
        step = 1'b1; mode_load = 1'b1; mode_req = 2'b11;
        tick(1);
        step = 1'b0; mode_load = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick(1);
            checks++;
            if (mem_we !== 1'b0 || CPUstate !== 2'b11 || cpu_run !== 1'b1 || own_mem !== 1'b0) begin
                errors++;
                $display("FAIL same_edge%0d got we=%b st=%b run=%b own=%b exp 0/11/1/0",
                         i, mem_we, CPUstate, cpu_run, own_mem);
            end
        end
        checks++;
        if (prog_len !== '0 || mem_addr !== '0) begin
            errors++;
            $display("FAIL same_edge_ptr got len=%0h a=%0h exp 0/0", prog_len, mem_addr);
        end
        press_step();
        tick(1);
        checks++;
        if (mem_we !== 1'b0 || mem_re !== 1'b0 || mem_addr !== '0) begin
            errors++;
            $display("FAIL run_step got we=%b re=%b a=%0h exp 0/0/0", mem_we, mem_re, mem_addr);
        end
        press_load(2'b00);
        checks++;
        if (cpu_run !== 1'b0 || CPUstate !== 2'b00) begin
            errors++;
            $display("FAIL leave_run got run=%b st=%b exp 0/00", cpu_run, CPUstate);
        end
    endtask

    task automatic test_wrap();
        logic [DW-1:0] d;
        press_load(2'b01);
        for (int i = 0; i < (1 << AW) - 1; i++) begin
            d = DW'($urandom);
            sw_data = d;
            press_step();
            model_write(d);
            tick(1);
        end
        checks++;
        if (mem_addr !== LEN_MAX || prog_len !== LEN_MAX || checksum !== exp_csum()) begin
            errors++;
            $display("FAIL wrap_pre got a=%0h len=%0h cs=%0h exp %0h/%0h/%0h",
                     mem_addr, prog_len, checksum, LEN_MAX, LEN_MAX, exp_csum());
        end
        d = DW'($urandom);
        sw_data = d;
        press_step();
        checks++;
        if (mem_we !== 1'b1 || mem_addr !== LEN_MAX || mem_wdata !== d) begin
            errors++;
            $display("FAIL wrap_wr got we=%b a=%0h wd=%0h exp 1/%0h/%0h", mem_we, mem_addr, mem_wdata, LEN_MAX, d);
        end
        model_write(d);
        tick(1);
        checks++;
        if (mem_addr !== '0 || exp_addr !== '0 || prog_len !== LEN_MAX || checksum !== exp_csum()) begin
            errors++;
            $display("FAIL wrap_after got a=%0h len=%0h cs=%0h exp 0/%0h/%0h",
                     mem_addr, prog_len, checksum, LEN_MAX, exp_csum());
        end
    endtask

    task automatic test_reset_mid();
        logic [DW-1:0] saved;
        saved = tb_mem[0];
        sw_data = ~saved;
        press_step();
        checks++;
        if (mem_we !== 1'b1 || mem_addr !== '0) begin
            errors++;
            $display("FAIL rst_mid_pre got we=%b a=%0h exp 1/0", mem_we, mem_addr);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (mem_we !== 1'b0 || CPUstate !== 2'b00 || own_mem !== 1'b0 || cpu_run !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_ctrl got we=%b st=%b own=%b run=%b exp 0/00/0/0", mem_we, CPUstate, own_mem, cpu_run);
        end
        checks++;
        if (mem_addr !== '0 || prog_len !== '0 || disp_data !== 8'h00 || mem_wdata !== 8'h00 || checksum !== 8'h00) begin
            errors++;
            $display("FAIL rst_mid_data got a=%0h len=%0h disp=%0h wd=%0h cs=%0h exp 0",
                     mem_addr, prog_len, disp_data, mem_wdata, checksum);
        end
        tick(2);
        checks++;
        if (tb_mem[0] !== saved) begin
            errors++;
            $display("FAIL rst_mid_nowrite got mem0=%0h exp %0h", tb_mem[0], saved);
        end
        rst = 1'b0;
        tick(2);
    endtask

    initial begin
        test_reset();
        test_enter_in();
        test_in_writes(3, 1'b1);
        exp_disp = 8'hFF;
        test_check(3);
        test_pending_load();
        begin
            int n;
            n = $urandom_range(4, 12);
            press_load(2'b01);
            test_in_writes(n, 1'b0);
            test_check(n);
        end
        test_same_edge();
        test_wrap();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1, "watchdog");
    end

endmodule
